// File: rtl/memory_map_ctrl.sv
// Data-space access controller: decodes byte addresses into GPR, IO and
// internal SRAM regions and sequences byte or 16-bit word transactions
// one byte at a time through a small FSM.

// Single-port byte-wide SRAM with one-cycle synchronous read.
module sram #(
    parameter int AW = 11
) (
    input  logic [AW-1:0] address,
    input  logic          clock,
    input  logic [7:0]    data,
    input  logic          wren,
    output logic [7:0]    q
);
    logic [7:0] mem_q [0:(1 << AW) - 1];

    // Write port and registered read port; contents are never reset.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem_q[address] <= data;
        end
        q <= mem_q[address];
    end
endmodule

module memory_map_ctrl #(
    parameter int NUM_GPR = 32,
    parameter int NUM_IO  = 64,
    parameter int SRAM_AW = 11,
    localparam int GW = $clog2(NUM_GPR),
    localparam int IW = $clog2(NUM_IO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic                 word,
    input  logic                 io_only,
    input  logic [15:0]          addr,
    input  logic [15:0]          wdata,
    input  logic [NUM_GPR*8-1:0] register_bus,
    input  logic [NUM_IO*8-1:0]  io_bus,
    output logic                 busy,
    output logic                 ack,
    output logic [15:0]          rdata,
    output logic                 err,
    output logic                 reg_we,
    output logic [GW-1:0]        reg_waddr,
    output logic [7:0]           reg_wdata,
    output logic                 io_we,
    output logic [IW-1:0]        io_waddr,
    output logic [7:0]           io_wdata
);
    localparam logic [16:0] IO_BASE_W   = 17'(NUM_GPR);
    localparam logic [16:0] SRAM_BASE_W = 17'(NUM_GPR + NUM_IO);
    localparam logic [16:0] SRAM_END_W  = 17'(NUM_GPR + NUM_IO + (1 << SRAM_AW));
    localparam logic [16:0] NUM_IO_W    = 17'(NUM_IO);
    localparam logic [15:0] IO_BASE_16  = 16'(NUM_GPR);
    localparam logic [15:0] SRAM_BASE_16 = 16'(NUM_GPR + NUM_IO);

    typedef enum logic [2:0] {
        S_IDLE, S_LO_ISSUE, S_LO_CAP, S_HI_ISSUE, S_HI_CAP, S_DONE
    } state_t;

    typedef enum logic [1:0] {R_NONE, R_GPR, R_IO, R_SRAM} region_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        word_q, word_d;
    logic        io_only_q, io_only_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic               hi_s;
    logic               issue_s;
    logic               cap_s;
    logic [15:0]        byte_addr_s;
    logic [7:0]         byte_wdata_s;
    region_t            region_s;
    logic [GW-1:0]      gpr_idx_s;
    logic [IW-1:0]      io_idx_s;
    logic [SRAM_AW-1:0] sram_idx_s;
    logic [7:0]         rd_byte_s;
    logic               sram_wren_s;
    logic [7:0]         sram_q_s;

    // Current byte address (high byte wraps at 16 bits) and its write data.
    always_comb begin
        hi_s         = (state_q == S_HI_ISSUE) || (state_q == S_HI_CAP);
        issue_s      = ((state_q == S_LO_ISSUE) || (state_q == S_HI_ISSUE)) && !rst;
        cap_s        = (state_q == S_LO_CAP) || (state_q == S_HI_CAP);
        byte_addr_s  = hi_s ? (addr_q + 16'd1) : addr_q;
        byte_wdata_s = hi_s ? wdata_q[15:8] : wdata_q[7:0];
    end

    // Region decode of the current byte, each byte decoded on its own.
    always_comb begin
        region_s   = R_NONE;
        gpr_idx_s  = GW'(byte_addr_s);
        io_idx_s   = IW'(byte_addr_s);
        sram_idx_s = SRAM_AW'(byte_addr_s - SRAM_BASE_16);
        if (io_only_q) begin
            if ({1'b0, byte_addr_s} < NUM_IO_W) begin
                region_s = R_IO;
            end else begin
                region_s = R_NONE;
            end
        end else begin
            if ({1'b0, byte_addr_s} < IO_BASE_W) begin
                region_s = R_GPR;
            end else if ({1'b0, byte_addr_s} < SRAM_BASE_W) begin
                region_s = R_IO;
                io_idx_s = IW'(byte_addr_s - IO_BASE_16);
            end else if ({1'b0, byte_addr_s} < SRAM_END_W) begin
                region_s = R_SRAM;
            end else begin
                region_s = R_NONE;
            end
        end
    end

    // Read byte selection; out-of-range bytes read as zero.
    always_comb begin
        case (region_s)
            R_GPR:   rd_byte_s = register_bus[{gpr_idx_s, 3'b000} +: 8];
            R_IO:    rd_byte_s = io_bus[{io_idx_s, 3'b000} +: 8];
            R_SRAM:  rd_byte_s = sram_q_s;
            default: rd_byte_s = 8'h00;
        endcase
    end

    // Write strobes: exactly one target per in-range byte, issue cycle only.
    always_comb begin
        sram_wren_s = issue_s && we_q && (region_s == R_SRAM);
        reg_we      = issue_s && we_q && (region_s == R_GPR);
        io_we       = issue_s && we_q && (region_s == R_IO);
        reg_waddr   = gpr_idx_s;
        reg_wdata   = byte_wdata_s;
        io_waddr    = io_idx_s;
        io_wdata    = byte_wdata_s;
    end

    sram #(.AW(SRAM_AW)) u_sram (
        .address (sram_idx_s),
        .clock   (clk),
        .data    (byte_wdata_s),
        .wren    (sram_wren_s),
        .q       (sram_q_s)
    );

    // Next-state logic for the FSM and the transaction registers.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        word_d    = word_q;
        io_only_d = io_only_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d   = S_LO_ISSUE;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    we_d      = we;
                    word_d    = word;
                    io_only_d = io_only;
                    rdata_d   = 16'h0000;
                    err_d     = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LO_ISSUE: state_d = S_LO_CAP;
            S_LO_CAP:   state_d = word_q ? S_HI_ISSUE : S_DONE;
            S_HI_ISSUE: state_d = S_HI_CAP;
            S_HI_CAP:   state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (cap_s) begin
            if (region_s == R_NONE) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if (we_q) begin
                rdata_d = rdata_q;
            end else if (hi_s) begin
                rdata_d[15:8] = rd_byte_s;
            end else begin
                rdata_d[7:0] = rd_byte_s;
            end
        end else begin
            err_d = err_d;
        end
    end

    // State and transaction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            we_q      <= 1'b0;
            word_q    <= 1'b0;
            io_only_q <= 1'b0;
            rdata_q   <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            word_q    <= word_d;
            io_only_q <= io_only_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign ack   = (state_q == S_DONE);
    assign rdata = rdata_q;
    assign err   = err_q;
endmodule

// File: tb/tb_memory_map_ctrl.sv
// Randomized self-checking bench for memory_map_ctrl against a byte-level
// memory model of the GPR, IO and SRAM regions.
module tb_memory_map_ctrl;
    localparam int NUM_GPR = 32;
    localparam int NUM_IO  = 64;
    localparam int SRAM_AW = 11;
    localparam int SRAM_N  = 1 << SRAM_AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        word = 1'b0;
    logic        io_only = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [NUM_GPR*8-1:0] register_bus;
    logic [NUM_IO*8-1:0]  io_bus;
    logic        busy, ack, err, reg_we, io_we;
    logic [15:0] rdata;
    logic [4:0]  reg_waddr;
    logic [7:0]  reg_wdata, io_wdata;
    logic [5:0]  io_waddr;

    logic [7:0] gpr_m  [0:NUM_GPR-1];
    logic [7:0] io_m   [0:NUM_IO-1];
    logic [7:0] sram_m [0:SRAM_N-1];
    int strobe_q [$];
    int checks = 0;
    int errors = 0;

    memory_map_ctrl #(.NUM_GPR(NUM_GPR), .NUM_IO(NUM_IO), .SRAM_AW(SRAM_AW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .word(word), .io_only(io_only),
        .addr(addr), .wdata(wdata), .register_bus(register_bus), .io_bus(io_bus),
        .busy(busy), .ack(ack), .rdata(rdata), .err(err),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .io_we(io_we), .io_waddr(io_waddr), .io_wdata(io_wdata)
    );

    always #5 clk = ~clk;

    // Present the model register and IO arrays as flattened buses.
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) register_bus[i*8 +: 8] = gpr_m[i];
        for (int i = 0; i < NUM_IO; i++) io_bus[i*8 +: 8] = io_m[i];
    end

    // Record every GPR/IO write strobe seen in a cycle.
    always @(negedge clk) begin
        if (reg_we) strobe_q.push_back(32'h10000 | (32'(reg_waddr) << 8) | 32'(reg_wdata));
        if (io_we)  strobe_q.push_back(32'h20000 | (32'(io_waddr) << 8) | 32'(io_wdata));
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Region of a byte address: 0 none, 1 GPR, 2 IO, 3 SRAM.
    function automatic void decode(input logic io, input logic [15:0] a,
                                   output int region, output int off);
        int ai;
        ai = int'(a);
        region = 0;
        off = 0;
        if (io) begin
            if (ai < NUM_IO) begin region = 2; off = ai; end
        end else if (ai < NUM_GPR) begin
            region = 1; off = ai;
        end else if (ai < NUM_GPR + NUM_IO) begin
            region = 2; off = ai - NUM_GPR;
        end else if (ai < NUM_GPR + NUM_IO + SRAM_N) begin
            region = 3; off = ai - NUM_GPR - NUM_IO;
        end
    endfunction

    task automatic do_txn(input logic w, input logic wd, input logic io,
                          input logic [15:0] a, input logic [15:0] wdat, input logic noise);
        logic [15:0] exp_rd;
        logic        exp_err;
        logic [15:0] ba;
        logic [7:0]  b, wb;
        int exp_str [$];
        int rg, of, lat, n, start;
        logic got;
        exp_rd = 16'h0000;
        exp_err = 1'b0;
        for (int i = 0; i < (wd ? 2 : 1); i++) begin
            ba = a + 16'(i);
            decode(io, ba, rg, of);
            b = 8'h00;
            wb = (i == 1) ? wdat[15:8] : wdat[7:0];
            if (rg == 0) begin
                exp_err = 1'b1;
            end else if (w) begin
                if (rg == 1) exp_str.push_back(32'h10000 | (of << 8) | int'(wb));
                else if (rg == 2) exp_str.push_back(32'h20000 | (of << 8) | int'(wb));
                else sram_m[of] = wb;
            end else begin
                if (rg == 1) b = gpr_m[of];
                else if (rg == 2) b = io_m[of];
                else b = sram_m[of];
            end
            exp_rd[i*8 +: 8] = b;
        end
        lat = wd ? 4 : 2;
        start = strobe_q.size();
        @(negedge clk);
        we = w; word = wd; io_only = io; addr = a; wdata = wdat; req = 1'b1;
        @(posedge clk); #1;
        check_val("busy_accept", {31'd0, busy}, 32'd1);
        n = 0;
        got = 1'b0;
        while (n < 12 && !got) begin
            @(negedge clk);
            req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            addr = 16'($urandom); we = 1'($urandom); word = 1'($urandom);
            io_only = 1'($urandom); wdata = 16'($urandom);
            @(posedge clk); #1;
            n++;
            if (ack) got = 1'b1;
            else check_val("busy_mid", {31'd0, busy}, 32'd1);
        end
        check_val("ack_seen", {31'd0, got}, 32'd1);
        check_val("ack_latency", n, lat);
        check_val("busy_at_ack", {31'd0, busy}, 32'd1);
        check_val("rdata", {16'd0, rdata}, {16'd0, exp_rd});
        check_val("err", {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        check_val("ack_pulse", {31'd0, ack}, 32'd0);
        check_val("busy_after", {31'd0, busy}, 32'd0);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        check_val("no_queue", {31'd0, busy}, 32'd0);
        check_val("strobe_count", strobe_q.size() - start, exp_str.size());
        for (int i = 0; i < exp_str.size() && start + i < strobe_q.size(); i++)
            check_val("strobe", strobe_q[start + i], exp_str[i]);
    endtask

    initial begin
        logic [15:0] a;
        int c, start;
        logic io, wd;
        for (int i = 0; i < NUM_GPR; i++) gpr_m[i] = 8'($urandom);
        for (int i = 0; i < NUM_IO; i++) io_m[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_ack", {31'd0, ack}, 32'd0);
        check_val("rst_rdata", {16'd0, rdata}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_reg_we", {31'd0, reg_we}, 32'd0);
        check_val("rst_io_we", {31'd0, io_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Prefill the SRAM windows used by later reads.
        for (int k = 0; k < 128; k++) do_txn(1'b1, 1'b1, 1'b0, 16'(96 + 2*k), 16'($urandom), 1'b0);
        for (int k = 0; k < 4; k++) do_txn(1'b1, 1'b1, 1'b0, 16'(2136 + 2*k), 16'($urandom), 1'b0);

        // Directed cases.
        gpr_m[5] = 8'hA5;
        do_txn(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1);
        do_txn(1'b1, 1'b1, 1'b0, 16'h0100, 16'h1234, 1'b1);
        do_txn(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1);
        check_val("sram_a0", {24'd0, sram_m[12'h0A0]}, 32'h34);
        check_val("sram_a1", {24'd0, sram_m[12'h0A1]}, 32'h12);
        io_m[63] = 8'h11;
        do_txn(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0022, 1'b0);
        do_txn(1'b0, 1'b1, 1'b0, 16'h005F, 16'h0000, 1'b0);
        do_txn(1'b1, 1'b0, 1'b0, 16'h003F, 16'h003C, 1'b0);
        do_txn(1'b1, 1'b0, 1'b1, 16'h001F, 16'h003C, 1'b0);
        do_txn(1'b0, 1'b0, 1'b0, 16'h0860, 16'h0000, 1'b0);
        do_txn(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0);
        do_txn(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);

        // Reset while the low byte of a word write is being captured.
        start = strobe_q.size();
        @(negedge clk);
        we = 1'b1; word = 1'b1; io_only = 1'b0; addr = 16'h0100; wdata = 16'hBEEF; req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_ack", {31'd0, ack}, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check_val("abort_no_ack", {31'd0, ack}, 32'd0);
        end
        check_val("abort_strobes", strobe_q.size() - start, 0);
        sram_m[12'h0A0] = 8'hEF;
        do_txn(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);

        // Randomized traffic across regions and boundaries.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < NUM_GPR; i++) gpr_m[i] = 8'($urandom);
            for (int i = 0; i < NUM_IO; i++) io_m[i] = 8'($urandom);
            c = $urandom_range(0, 5);
            io = 1'b0;
            wd = 1'($urandom);
            case (c)
                0: a = 16'($urandom_range(0, 31));
                1: a = 16'($urandom_range(32, 95));
                2: a = 16'($urandom_range(96, 96 + 250));
                3: a = 16'($urandom_range(2136, 2150));
                4: a = 16'($urandom_range(16'hFFF8, 16'hFFFF));
                default: begin a = 16'($urandom_range(0, 70)); io = 1'b1; end
            endcase
            do_txn(1'($urandom), wd, io, a, 16'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_map_ctrl.md
MEMORY_MAP_CTRL -- requirements
Module: memory_map_ctrl

Interface
REQ-001 SHALL have parameter NUM_GPR, default 32, general-purpose register count, mapped at data address 0.
REQ-002 SHALL have parameter NUM_IO, default 64, IO register count, mapped at IO_BASE = NUM_GPR.
REQ-003 SHALL have parameter SRAM_AW, default 11, internal SRAM address width, mapped at SRAM_BASE = NUM_GPR+NUM_IO, depth 2^SRAM_AW.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  1  access request; sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read.
REQ-008 word  input  1  1 = 16-bit access, 0 = byte access.
REQ-009 io_only  input  1  1 = addr is a raw IO index (0..NUM_IO-1).
REQ-010 addr  input  16  data-space byte address.
REQ-011 wdata  input  16  write data; byte access uses [7:0].
REQ-012 register_bus  input  NUM_GPR*8  flattened GPR contents, Rn at [n*8 +: 8].
REQ-013 io_bus  input  NUM_IO*8  flattened IO contents, IOn at [n*8 +: 8].
REQ-014 busy  output  1  transaction in progress.
REQ-015 ack  output  1  one-cycle completion pulse.
REQ-016 rdata  output  16  read result; valid while ack=1, held until next acceptance.
REQ-017 err  output  1  any byte of the transaction out of range; valid while ack=1.
REQ-018 reg_we / reg_waddr / reg_wdata  output  1 / clog2(NUM_GPR) / 8  GPR write strobe, index, data.
REQ-019 io_we / io_waddr / io_wdata  output  1 / clog2(NUM_IO) / 8  IO write strobe, index, data.

Function
REQ-020 SHALL contain one internal sram instance (address, clock, data, wren, q; 1-cycle synchronous read latency).
REQ-021 Byte decode (io_only=0): a < IO_BASE -> GPR a; a < SRAM_BASE -> IO a-IO_BASE; a < SRAM_BASE+2^SRAM_AW -> SRAM a-SRAM_BASE; else out of range.
REQ-022 Byte decode (io_only=1): a < NUM_IO -> IO a; else out of range.
REQ-023 Word access: low byte at addr -> rdata/wdata[7:0], high byte at addr+1 (16-bit wrap, 0xFFFF+1=0x0000) -> [15:8]; each byte decoded independently, region straddling permitted.
REQ-024 FSM states: IDLE, LO_ISSUE, LO_CAP, HI_ISSUE, HI_CAP, DONE.
REQ-025 IDLE: busy=0; edge with req=1 latches addr/we/word/io_only/wdata, clears rdata and err, goes LO_ISSUE.
REQ-026 LO_ISSUE/HI_ISSUE: drive sram address/wren for the current byte; for writes assert exactly one of sram wren, reg_we, io_we for this cycle only; next state is the matching CAP.
REQ-027 LO_CAP/HI_CAP: read captures selected byte (SRAM q, register_bus, or io_bus sampled this edge) into rdata; LO_CAP goes HI_ISSUE if word else DONE; HI_CAP goes DONE.
REQ-028 DONE: ack=1 for one cycle, next IDLE; a req in DONE is not accepted.
REQ-029 Latency from accepting edge E: byte ack high between E+2 and E+3; word ack high between E+4 and E+5; busy=1 from E through the ack cycle.
REQ-030 req in any non-IDLE state SHALL be ignored and not queued.
REQ-031 Out-of-range byte: read returns 0x00, write produces no strobe, err set for the transaction.
REQ-032 Write transactions SHALL return rdata=0x0000.

Reset
REQ-033 rst=1 at an edge: state IDLE; busy, ack, err, reg_we, io_we, sram wren = 0; rdata=0x0000; sets priority over req.
REQ-034 Reset mid-transaction aborts it: no further strobes, no ack; SRAM contents preserved.

Verification
REQ-035 R5=0xA5 in register_bus, byte read 0x0005 -> ack between E+2 and E+3, rdata=0x00A5, err=0.
REQ-036 Word write 0x1234 to 0x0100, then word read 0x0100 -> rdata=0x1234; SRAM index 0x0A0=0x34, 0x0A1=0x12.
REQ-037 IO63=0x11, SRAM 0x0060 holds 0x22, word read 0x005F -> rdata=0x2211, err=0.
REQ-038 Byte write 0x3C to 0x003F -> io_we one cycle, io_waddr=0x1F, io_wdata=0x3C, reg_we=0; repeat with io_only=1 addr 0x001F -> same strobe.
REQ-039 Byte read 0x0860 -> rdata=0x0000, err=1; io_only=1 byte read 0x0040 -> err=1.
REQ-040 Word write started, rst asserted in HI_ISSUE-preceding LO_CAP -> low byte written, high byte unchanged, no ack, busy=0 after reset edge.
